// File: rtl/mem_stage.sv
// Memory-access pipeline stage: registers execute results, runs one valid/ack
// data-memory transaction at a time, and aligns/extends load data for write-back.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rd_write_enable,
  input  logic [4:0]  rd_write_addr,
  input  logic [1:0]  res_src,
  input  logic        mem_write_enable,
  input  logic [2:0]  mem_width,
  input  logic [31:0] exec_out,
  input  logic [31:0] mem_write_data,
  input  logic [31:0] next_pc,
  output logic [31:0] mem_forward,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        rd_write_enable_out,
  output logic [4:0]  rd_write_addr_out,
  output logic [31:0] wb_data_out,
  output logic        misaligned_out,
  output logic        bus_error_out
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state_q;
  logic [CW-1:0] waitCnt_q;
  logic          rdWe_q;
  logic [4:0]    rdAddr_q;
  logic [31:0]   wbData_q;
  logic          misaligned_q;
  logic          busError_q;

  logic        access;
  logic        misaligned;
  logic        misFault;
  logic        memAccess;
  logic        inWait;
  logic        timedOut;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic [31:0] shifted;
  logic [31:0] loadData;
  logic [31:0] wbSel;

  assign access    = (res_src == 2'b01) | mem_write_enable;
  assign misFault  = access & misaligned;
  assign memAccess = access & ~misaligned;

  always_comb begin
    misaligned = 1'b0;
    case (mem_width[1:0])
      2'b01:   misaligned = exec_out[0];
      2'b10:   misaligned = (exec_out[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

  always_comb begin
    wstrb = 4'b0000;
    wdata = mem_write_data;
    case (mem_width[1:0])
      2'b00: begin
        wstrb = 4'b0001 << exec_out[1:0];
        wdata = {4{mem_write_data[7:0]}};
      end
      2'b01: begin
        wstrb = exec_out[1] ? 4'b1100 : 4'b0011;
        wdata = {2{mem_write_data[15:0]}};
      end
      default: wstrb = 4'b1111;
    endcase
    if (!mem_write_enable) wstrb = 4'b0000;
  end

  // Bring the addressed byte/half down to bit 0 before extending.
  assign shifted = dmem_rdata >> {exec_out[1:0], 3'b000};

  always_comb begin
    loadData = dmem_rdata;
    case (mem_width)
      3'b000:  loadData = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  loadData = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  loadData = {24'b0, shifted[7:0]};
      3'b101:  loadData = {16'b0, shifted[15:0]};
      default: loadData = dmem_rdata;
    endcase
  end

  always_comb begin
    wbSel = 32'b0;
    case (res_src)
      2'b00:   wbSel = exec_out;
      2'b01:   wbSel = loadData;
      2'b10:   wbSel = next_pc;
      default: wbSel = 32'b0;
    endcase
  end

  assign inWait   = (state_q == WAIT);
  assign timedOut = inWait & (waitCnt_q == TMAX);

  // A timed-out access drops req and retires even if a stray ack shows up.
  assign dmem_req = rst_n & (inWait ? ~timedOut : memAccess);
  assign stall    = inWait ? (~dmem_ack & ~timedOut) : (memAccess & ~dmem_ack);

  assign mem_forward = exec_out;
  assign dmem_we     = mem_write_enable;
  assign dmem_addr   = {exec_out[31:2], 2'b00};
  assign dmem_wdata  = wdata;
  assign dmem_wstrb  = wstrb;

  assign rd_write_enable_out = rdWe_q;
  assign rd_write_addr_out   = rdAddr_q;
  assign wb_data_out         = wbData_q;
  assign misaligned_out      = misaligned_q;
  assign bus_error_out       = busError_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      waitCnt_q    <= '0;
      rdWe_q       <= 1'b0;
      rdAddr_q     <= 5'b0;
      wbData_q     <= 32'b0;
      misaligned_q <= 1'b0;
      busError_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (memAccess && !dmem_ack) begin
            state_q   <= WAIT;
            waitCnt_q <= CW'(1);
          end
        end
        WAIT: begin
          if (dmem_ack || timedOut) begin
            state_q   <= IDLE;
            waitCnt_q <= '0;
          end else begin
            waitCnt_q <= waitCnt_q + 1'b1;
          end
        end
      endcase

      if (stall) begin
        rdWe_q       <= 1'b0;
        misaligned_q <= 1'b0;
        busError_q   <= 1'b0;
      end else begin
        rdWe_q       <= rd_write_enable & ~misFault & ~timedOut;
        rdAddr_q     <= rd_write_addr;
        wbData_q     <= wbSel;
        misaligned_q <= misFault;
        busError_q   <= timedOut;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed vector table, reset/late-ack sequences, and
// random instructions checked against a behavioural model of the stage.
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_write_enable;
  logic [4:0]  rd_write_addr;
  logic [1:0]  res_src;
  logic        mem_write_enable;
  logic [2:0]  mem_width;
  logic [31:0] exec_out;
  logic [31:0] mem_write_data;
  logic [31:0] next_pc;
  logic [31:0] mem_forward;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        rd_write_enable_out;
  logic [4:0]  rd_write_addr_out;
  logic [31:0] wb_data_out;
  logic        misaligned_out;
  logic        bus_error_out;

  int checks = 0;
  int errors = 0;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .rd_write_enable     (rd_write_enable),
    .rd_write_addr       (rd_write_addr),
    .res_src             (res_src),
    .mem_write_enable    (mem_write_enable),
    .mem_width           (mem_width),
    .exec_out            (exec_out),
    .mem_write_data      (mem_write_data),
    .next_pc             (next_pc),
    .mem_forward         (mem_forward),
    .stall               (stall),
    .dmem_req            (dmem_req),
    .dmem_we             (dmem_we),
    .dmem_addr           (dmem_addr),
    .dmem_wdata          (dmem_wdata),
    .dmem_wstrb          (dmem_wstrb),
    .dmem_ack            (dmem_ack),
    .dmem_rdata          (dmem_rdata),
    .rd_write_enable_out (rd_write_enable_out),
    .rd_write_addr_out   (rd_write_addr_out),
    .wb_data_out         (wb_data_out),
    .misaligned_out      (misaligned_out),
    .bus_error_out       (bus_error_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdWe;
    logic [4:0]  rdAddr;
    logic [1:0]  resSrc;
    logic        memWe;
    logic [2:0]  width;
    logic [31:0] execOut;
    logic [31:0] wdata;
    logic [31:0] nextPc;
    logic [31:0] rdata;
    int          ackDelay;
  } instr_t;

  typedef struct {
    int          stallCycles;
    logic        rdWe;
    logic [31:0] wb;
    logic        mis;
    logic        bus;
    logic        req;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        checkWb;
  } expect_t;

  typedef struct {
    instr_t  in;
    expect_t ex;
  } vec_t;

  function automatic instr_t mkI(logic rdWe, logic [4:0] rdAddr, logic [1:0] resSrc,
                                 logic memWe, logic [2:0] width, logic [31:0] execOut,
                                 logic [31:0] wdata, logic [31:0] nextPc,
                                 logic [31:0] rdata, int ackDelay);
    instr_t i;
    i.rdWe = rdWe; i.rdAddr = rdAddr; i.resSrc = resSrc; i.memWe = memWe;
    i.width = width; i.execOut = execOut; i.wdata = wdata; i.nextPc = nextPc;
    i.rdata = rdata; i.ackDelay = ackDelay;
    return i;
  endfunction

  function automatic expect_t mkE(int stallCycles, logic rdWe, logic [31:0] wb,
                                  logic mis, logic bus, logic req, logic we,
                                  logic [3:0] wstrb, logic [31:0] wdata, logic checkWb);
    expect_t e;
    e.stallCycles = stallCycles; e.rdWe = rdWe; e.wb = wb; e.mis = mis; e.bus = bus;
    e.req = req; e.we = we; e.wstrb = wstrb; e.wdata = wdata; e.checkWb = checkWb;
    return e;
  endfunction

  // Reference model: derives everything from access size, byte lane and ack latency.
  function automatic expect_t model(instr_t in);
    expect_t e;
    int      size;
    int      lane;
    logic    access;
    longint  v;
    logic [31:0] load;
    access = (in.resSrc == 2'd1) || in.memWe;
    size   = (in.width[1:0] == 2'd0) ? 1 : (in.width[1:0] == 2'd1) ? 2 : 4;
    lane   = int'(in.execOut % 4);
    e.mis  = access && ((in.execOut % size) != 0);
    e.req  = access && !e.mis;
    e.bus  = e.req && (in.ackDelay < 0);
    e.stallCycles = !e.req ? 0 : (e.bus ? TO : in.ackDelay);
    e.we    = in.memWe;
    e.wstrb = in.memWe ? 4'(((1 << size) - 1) << lane) : 4'd0;
    e.wdata = (size == 1) ? (in.wdata & 32'hFF) * 32'h0101_0101 :
              (size == 2) ? (in.wdata & 32'hFFFF) * 32'h0001_0001 : in.wdata;
    v = longint'(in.rdata >> (8 * lane));
    if (size < 4) begin
      v = v % (longint'(1) << (8 * size));
      if (!in.width[2] && v >= (longint'(1) << (8 * size - 1)))
        v = v - (longint'(1) << (8 * size));
    end
    load = 32'(v);
    case (in.resSrc)
      2'd0:    e.wb = in.execOut;
      2'd1:    e.wb = load;
      2'd2:    e.wb = in.nextPc;
      default: e.wb = 32'd0;
    endcase
    e.rdWe    = in.rdWe && !e.mis && !e.bus;
    e.checkWb = (in.resSrc != 2'd1) || (e.req && !e.bus);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input instr_t in);
    rd_write_enable  = in.rdWe;
    rd_write_addr    = in.rdAddr;
    res_src          = in.resSrc;
    mem_write_enable = in.memWe;
    mem_width        = in.width;
    exec_out         = in.execOut;
    mem_write_data   = in.wdata;
    next_pc          = in.nextPc;
  endtask

  // Called at a falling edge; returns at the falling edge after the instruction retires.
  task automatic runInstr(input instr_t in, input expect_t ex, input string tag);
    logic expStall;
    logic expReq;
    applyStimulus(in);
    for (int c = 0; c <= TO + 1; c++) begin
      dmem_ack   = ex.req && (c == in.ackDelay);
      dmem_rdata = (c == in.ackDelay) ? in.rdata : $urandom();
      #1;
      expStall = (c < ex.stallCycles);
      expReq   = ex.req && (in.ackDelay >= 0 || c < TO);
      checkOutput({tag, ".stall"}, 32'(stall), 32'(expStall));
      checkOutput({tag, ".req"}, 32'(dmem_req), 32'(expReq));
      if (c == 0) begin
        checkOutput({tag, ".fwd"}, mem_forward, in.execOut);
        if (ex.req) begin
          checkOutput({tag, ".addr"}, dmem_addr, in.execOut & 32'hFFFF_FFFC);
          checkOutput({tag, ".we"}, 32'(dmem_we), 32'(ex.we));
          checkOutput({tag, ".wstrb"}, 32'(dmem_wstrb), 32'(ex.wstrb));
          if (ex.we) checkOutput({tag, ".wdata"}, dmem_wdata, ex.wdata);
        end
      end
      @(posedge clk);
      @(negedge clk);
      if (!expStall) break;
      checkOutput({tag, ".bubble"}, 32'(rd_write_enable_out), 32'd0);
    end
    dmem_ack = 1'b0;
    checkOutput({tag, ".rdWe"}, 32'(rd_write_enable_out), 32'(ex.rdWe));
    if (ex.rdWe) checkOutput({tag, ".rdAddr"}, 32'(rd_write_addr_out), 32'(in.rdAddr));
    if (ex.checkWb) checkOutput({tag, ".wb"}, wb_data_out, ex.wb);
    checkOutput({tag, ".mis"}, 32'(misaligned_out), 32'(ex.mis));
    checkOutput({tag, ".bus"}, 32'(bus_error_out), 32'(ex.bus));
  endtask

  function automatic instr_t randInstr();
    instr_t i;
    logic [2:0] loadW[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    int kind;
    int d;
    kind = $urandom_range(0, 4);
    i = mkI(1'($urandom()), 5'($urandom()), 2'd0, 1'b0, 3'($urandom_range(0, 2)),
            $urandom(), $urandom(), $urandom(), $urandom(), -1);
    d = $urandom_range(0, TO);
    i.ackDelay = (d == TO) ? -1 : d;
    case (kind)
      1: begin i.resSrc = 2'd1; i.width = loadW[$urandom_range(0, 4)]; end
      2: i.memWe = 1'b1;
      3: i.resSrc = 2'd2;
      4: i.resSrc = 2'd3;
      default: i.resSrc = 2'd0;
    endcase
    return i;
  endfunction

  vec_t vecs[16];

  initial begin
    instr_t ri;

    vecs[0].in  = mkI(1, 5, 0, 0, 3'b010, 32'h1234, 0, 0, 0, -1);
    vecs[0].ex  = mkE(0, 1, 32'h1234, 0, 0, 0, 0, 0, 0, 1);
    vecs[1].in  = mkI(1, 7, 1, 0, 3'b000, 32'h103, 0, 0, 32'h80FF_0000, 2);
    vecs[1].ex  = mkE(2, 1, 32'hFFFF_FF80, 0, 0, 1, 0, 0, 0, 1);
    vecs[2].in  = mkI(1, 7, 1, 0, 3'b100, 32'h103, 0, 0, 32'h80FF_0000, 2);
    vecs[2].ex  = mkE(2, 1, 32'h0000_0080, 0, 0, 1, 0, 0, 0, 1);
    vecs[3].in  = mkI(0, 3, 0, 1, 3'b001, 32'h202, 32'h0000_ABCD, 0, 0, 0);
    vecs[3].ex  = mkE(0, 0, 32'h202, 0, 0, 1, 1, 4'b1100, 32'hABCD_ABCD, 1);
    vecs[4].in  = mkI(1, 9, 1, 0, 3'b010, 32'h6, 0, 0, 0, -1);
    vecs[4].ex  = mkE(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[5].in  = mkI(1, 10, 1, 0, 3'b010, 32'h40, 0, 0, 0, -1);
    vecs[5].ex  = mkE(TO, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    vecs[6].in  = mkI(1, 1, 2, 0, 3'b000, 32'h999, 0, 32'h44, 0, -1);
    vecs[6].ex  = mkE(0, 1, 32'h44, 0, 0, 0, 0, 0, 0, 1);
    vecs[7].in  = mkI(1, 2, 3, 0, 3'b000, 32'h999, 0, 32'h44, 0, -1);
    vecs[7].ex  = mkE(0, 1, 32'h0, 0, 0, 0, 0, 0, 0, 1);
    vecs[8].in  = mkI(1, 11, 1, 0, 3'b001, 32'h102, 0, 0, 32'h8001_0000, 1);
    vecs[8].ex  = mkE(1, 1, 32'hFFFF_8001, 0, 0, 1, 0, 0, 0, 1);
    vecs[9].in  = mkI(1, 11, 1, 0, 3'b101, 32'h102, 0, 0, 32'h8001_0000, 1);
    vecs[9].ex  = mkE(1, 1, 32'h0000_8001, 0, 0, 1, 0, 0, 0, 1);
    vecs[10].in = mkI(1, 12, 0, 1, 3'b000, 32'h301, 32'h1234_565A, 0, 0, 3);
    vecs[10].ex = mkE(3, 1, 32'h301, 0, 0, 1, 1, 4'b0010, 32'h5A5A_5A5A, 1);
    vecs[11].in = mkI(0, 0, 0, 1, 3'b010, 32'h400, 32'hDEAD_BEEF, 0, 0, 0);
    vecs[11].ex = mkE(0, 0, 32'h400, 0, 0, 1, 1, 4'b1111, 32'hDEAD_BEEF, 1);
    vecs[12].in = mkI(0, 0, 0, 1, 3'b001, 32'h201, 32'hFFFF, 0, 0, 0);
    vecs[12].ex = mkE(0, 0, 32'h201, 1, 0, 0, 1, 0, 0, 1);
    vecs[13].in = mkI(1, 13, 1, 0, 3'b010, 32'h500, 0, 0, 32'h1234_5678, TO - 1);
    vecs[13].ex = mkE(TO - 1, 1, 32'h1234_5678, 0, 0, 1, 0, 0, 0, 1);
    vecs[14].in = mkI(1, 14, 1, 0, 3'b000, 32'h600, 0, 0, 32'h0000_007F, 0);
    vecs[14].ex = mkE(0, 1, 32'h0000_007F, 0, 0, 1, 0, 0, 0, 1);
    vecs[15].in = mkI(1, 15, 1, 0, 3'b001, 32'h602, 0, 0, 32'hFFFE_1234, 0);
    vecs[15].ex = mkE(0, 1, 32'hFFFF_FFFE, 0, 0, 1, 0, 0, 0, 1);

    rst_n = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = 32'h0;
    applyStimulus(mkI(0, 0, 0, 0, 3'b000, 0, 0, 0, 0, -1));
    repeat (3) @(negedge clk);
    checkOutput("reset.rdWe", 32'(rd_write_enable_out), 32'd0);
    checkOutput("reset.wb", wb_data_out, 32'd0);
    checkOutput("reset.req", 32'(dmem_req), 32'd0);
    checkOutput("reset.stall", 32'(stall), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 16; i++)
      runInstr(vecs[i].in, vecs[i].ex, $sformatf("vec%0d", i));

    // A stray ack while no access is pending must not disturb a plain ALU op.
    applyStimulus(mkI(1, 20, 0, 0, 3'b010, 32'hCAFE_0001, 0, 0, 0, -1));
    dmem_ack = 1'b1;
    #1;
    checkOutput("lateAck.stall", 32'(stall), 32'd0);
    @(posedge clk);
    @(negedge clk);
    dmem_ack = 1'b0;
    checkOutput("lateAck.rdWe", 32'(rd_write_enable_out), 32'd1);
    checkOutput("lateAck.wb", wb_data_out, 32'hCAFE_0001);

    // Reset while a load is parked in WAIT.
    runInstr(vecs[6].in, vecs[6].ex, "preRst");
    applyStimulus(mkI(1, 21, 1, 0, 3'b010, 32'h80, 0, 0, 0, -1));
    #1;
    checkOutput("rstWait.stall0", 32'(stall), 32'd1);
    @(posedge clk);
    @(negedge clk);
    checkOutput("rstWait.req1", 32'(dmem_req), 32'd1);
    checkOutput("rstWait.stall1", 32'(stall), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstWait.reqLow", 32'(dmem_req), 32'd0);
    checkOutput("rstWait.wb", wb_data_out, 32'd0);
    checkOutput("rstWait.rdAddr", 32'(rd_write_addr_out), 32'd0);
    checkOutput("rstWait.flags", {30'd0, misaligned_out, bus_error_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    runInstr(vecs[8].in, vecs[8].ex, "postRst");

    for (int n = 0; n < 200; n++) begin
      ri = randInstr();
      runInstr(ri, model(ri), $sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Pipeline memory-access stage, between the execute stage and write-back. It registers execute results, performs loads and stores over a single-outstanding valid/ack data-memory port, and aligns, masks and sign-extends load data. It selects the write-back value and stalls the upstream pipeline while a memory transaction is pending.

## Interface
Parameters:
- TIMEOUT, 16: max cycles waiting for dmem_ack before the access is aborted as a bus error (≥2).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
  - clk  in  1  rising-edge clock.
  - rst_n  in  1  asynchronous active-low reset.
- From execute stage:
  - rd_write_enable  in  1  destination write enable.
  - rd_write_addr  in  5  destination register.
  - res_src  in  2  result select: 00 ALU, 01 load, 10 next_pc, 11 reserved.
  - mem_write_enable  in  1  store request.
  - mem_width  in  3  funct3 width: 000 B, 001 H, 010 W, 100 BU, 101 HU.
  - exec_out  in  32  ALU result / effective address.
  - mem_write_data  in  32  store data, right-aligned.
  - next_pc  in  32  link value for JAL/JALR.
- Forwarding and control:
  - mem_forward  out  32  equals exec_out, combinational; forwarding source for execute.
  - stall  out  1  freeze upstream stages; inputs must be held stable while high.
- Data memory port:
  - dmem_req  out  1  request.
  - dmem_we  out  1  1 = write.
  - dmem_addr  out  32  {exec_out[31:2], 2'b00}.
  - dmem_wdata  out  32  lane-replicated store data.
  - dmem_wstrb  out  4  byte enables; 0 on reads.
  - dmem_ack  in  1  completion; rdata valid on reads.
  - dmem_rdata  in  32  read word.
- To write-back, all registered:
  - rd_write_enable_out  out  1  write enable.
  - rd_write_addr_out  out  5  destination register.
  - wb_data_out  out  32  write-back value.
  - misaligned_out  out  1  exception flag for the retiring instruction.
  - bus_error_out  out  1  exception flag for the retiring instruction.

## Operation
- Access condition: access = (res_src==01) | mem_write_enable.
- Misaligned:
  - H/HU with addr[0]=1, or W with addr[1:0]≠00.
  - No request is issued, rd write is suppressed, misaligned_out=1.
- Store lanes:
  - B: wstrb = 0001<<addr[1:0], wdata = {4{d[7:0]}}.
  - H: wstrb = 0011 or 1100 by addr[1], wdata = {2{d[15:0]}}.
  - W: wstrb = 1111, wdata = d.
- Load:
  - The byte or half is selected from dmem_rdata by addr[1:0].
  - Sign-extended for B/H, zero-extended for BU/HU.
- wb_data select: 00 → exec_out, 01 → load result, 10 → next_pc, 11 → 0.
- FSM IDLE:
  - dmem_req = access & ~misaligned (combinational).
  - If dmem_ack is high in the same cycle: complete, no stall.
  - Otherwise: stall=1, go to WAIT, wait counter = 1.
- FSM WAIT:
  - req held high, stall=1, counter increments each cycle.
  - On dmem_ack: complete, stall=0 in that cycle, go to IDLE.
  - When counter reaches TIMEOUT with no ack: abort.
    - req low, stall=0, retire with rd write suppressed and bus_error_out=1.
    - Go to IDLE.
- Output register update:
  - Loads the retiring instruction on the rising edge when stall=0.
  - Loads a bubble (rd_write_enable_out=0, flags 0, data unchanged) when stall=1.

## Timing
- Non-memory instruction: 1-cycle latency, input to write-back outputs.
- Memory access with ack in cycle k after the request (k=0 same cycle): stall high for k cycles; outputs valid k+1 edges after inputs.
- Single outstanding transaction; req never deasserts before ack or abort.
- dmem_addr, we, wstrb and wdata are stable while req is high.
- A late ack arriving after an abort is ignored in IDLE only if access=0. Memory shall not ack an aborted request.
- Reset (any time, including WAIT):
  - All registered outputs 0, state IDLE, counter 0.
  - dmem_req drops with rst_n low, since it is gated by state and by rst_n.

## Test plan
- ADD result 0x0000_1234, res_src=00, rd=5, no access → next edge: rd_write_enable_out=1, rd_write_addr_out=5, wb_data_out=0x1234, stall never high.
- LB from address 0x103, dmem_rdata=0x80FF_0000, ack after 2 cycles → stall high 2 cycles, dmem_addr=0x100, wb_data_out=0xFFFF_FF80. LBU with the same stimulus → 0x0000_0080.
- SH data 0x0000_ABCD to address 0x202, immediate ack → dmem_we=1, wstrb=1100, wdata=0xABCD_ABCD, rd_write_enable_out=0.
- LW from address 0x06 → no dmem_req, misaligned_out=1, rd_write_enable_out=0, no stall.
- LW, TIMEOUT=4, ack never → stall high 4 cycles, then req low, bus_error_out=1, rd_write_enable_out=0, state IDLE.
- JAL res_src=10, next_pc=0x44 → wb_data_out=0x44. Assert rst_n low during a pending LW in WAIT → req low immediately, all outputs 0 after reset.
